// File: rtl/bsg_gateway_power_seq.sv
// N-rail power sequencer: ascending power-up with settle/power-good checks,
// reverse-order power-down, fault shutdown and a CPU override bypass.
module bsg_gateway_power_seq #(
    parameter int num_rails_p     = 3,
    parameter int delay_width_p   = 24,
    parameter int default_delay_p = 1000000,
    parameter int good_timeout_p  = 65535,
    parameter int rail_id_width_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic                       cfg_v_i,
    input  logic [rail_id_width_p-1:0] cfg_rail_i,
    input  logic [delay_width_p-1:0]   cfg_delay_i,
    input  logic                       override_i,
    input  logic [num_rails_p-1:0]     override_val_i,
    input  logic [num_rails_p-1:0]     rail_good_i,
    input  logic                       clear_fault_i,
    output logic [num_rails_p-1:0]     rail_en_o,
    output logic                       done_o,
    output logic                       fault_o,
    output logic [rail_id_width_p-1:0] fault_rail_o,
    output logic [2:0]                 state_o
);

    localparam int GW = $clog2(good_timeout_p + 1);
    localparam logic [rail_id_width_p-1:0] LAST = rail_id_width_p'(num_rails_p - 1);
    localparam logic [GW-1:0]              GT   = GW'(good_timeout_p);
    localparam logic [delay_width_p-1:0]   DEF  = delay_width_p'(default_delay_p);
    localparam logic [delay_width_p-1:0]   ONE  = delay_width_p'(1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_UP    = 3'd1,
        S_ON    = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e                                    state_q;
    logic [rail_id_width_p-1:0]                idx_q;
    logic [delay_width_p-1:0]                  cnt_q;
    logic [GW-1:0]                             gcnt_q;
    logic [num_rails_p-1:0][delay_width_p-1:0] delay_q;
    logic [num_rails_p-1:0]                    rail_en_q;
    logic                                      done_q;
    logic                                      fault_q;
    logic [rail_id_width_p-1:0]                fault_rail_q;
    logic                                      ovr_q;

    logic [num_rails_p-1:0]     bad;
    logic [rail_id_width_p-1:0] bad_idx;
    logic                       cfg_we;

    assign bad    = rail_en_q & ~rail_good_i;
    assign cfg_we = cfg_v_i && !override_i && (state_q == S_OFF) && (cfg_rail_i <= LAST);

    // Lowest failing rail wins the fault report.
    always_comb begin
        bad_idx = '0;
        for (int i = num_rails_p - 1; i >= 0; i--)
            if (bad[i]) bad_idx = rail_id_width_p'(i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) delay_q <= {num_rails_p{DEF}};
        else if (cfg_we) delay_q[cfg_rail_i] <= cfg_delay_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            gcnt_q       <= '0;
            rail_en_q    <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
            ovr_q        <= 1'b0;
        end else begin
            ovr_q <= override_i;
            if (override_i) begin
                state_q   <= S_OFF;
                rail_en_q <= override_val_i;
                idx_q     <= '0;
                cnt_q     <= '0;
                gcnt_q    <= '0;
                done_q    <= 1'b0;
                fault_q   <= 1'b0;
            end else if (ovr_q) begin
                // First cycle after release: drop the CPU-driven enables before resequencing.
                state_q   <= S_OFF;
                rail_en_q <= '0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        rail_en_q <= '0;
                        idx_q     <= '0;
                        gcnt_q    <= '0;
                        if (en_i) begin
                            state_q   <= S_UP;
                            rail_en_q <= num_rails_p'(1);
                            cnt_q     <= delay_q[0];
                        end
                    end
                    S_UP: begin
                        if (cnt_q == '0 && !rail_good_i[idx_q] && gcnt_q == GT) begin
                            state_q      <= S_FAULT;
                            rail_en_q    <= '0;
                            fault_q      <= 1'b1;
                            fault_rail_q <= idx_q;
                        end else if (!en_i) begin
                            // Abort: the settling rail is the first to come down.
                            state_q          <= S_DOWN;
                            rail_en_q[idx_q] <= 1'b0;
                            cnt_q            <= delay_q[idx_q];
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (rail_good_i[idx_q]) begin
                            gcnt_q <= '0;
                            if (idx_q == LAST) begin
                                state_q <= S_ON;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q                   <= idx_q + 1'b1;
                                rail_en_q[idx_q + 1'b1] <= 1'b1;
                                cnt_q                   <= delay_q[idx_q + 1'b1];
                            end
                        end else begin
                            gcnt_q <= gcnt_q + 1'b1;
                        end
                    end
                    S_ON: begin
                        if (|bad) begin
                            state_q      <= S_FAULT;
                            rail_en_q    <= '0;
                            done_q       <= 1'b0;
                            fault_q      <= 1'b1;
                            fault_rail_q <= bad_idx;
                        end else if (!en_i) begin
                            state_q         <= S_DOWN;
                            done_q          <= 1'b0;
                            idx_q           <= LAST;
                            rail_en_q[LAST] <= 1'b0;
                            cnt_q           <= delay_q[LAST];
                        end
                    end
                    S_DOWN: begin
                        // idx_q is the rail most recently switched off.
                        if (idx_q == '0) begin
                            state_q <= S_OFF;
                        end else if (cnt_q > ONE) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            idx_q                   <= idx_q - 1'b1;
                            rail_en_q[idx_q - 1'b1] <= 1'b0;
                            cnt_q                   <= delay_q[idx_q - 1'b1];
                        end
                    end
                    S_FAULT: begin
                        rail_en_q <= '0;
                        if (clear_fault_i && !en_i) begin
                            state_q <= S_OFF;
                            fault_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_OFF;
                endcase
            end
        end
    end

    assign rail_en_o    = rail_en_q;
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign fault_rail_o = fault_rail_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_bsg_gateway_power_seq.sv
// Directed bench for the power sequencer: expectations are queued with a
// target cycle and checked by an independent monitor on the falling edge.
module tb_bsg_gateway_power_seq;

    localparam logic [2:0] OFF = 3'd0, UP = 3'd1, ON = 3'd2, DOWN = 3'd3, FLT = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n, en, cfg_v, ovr, clr;
    logic [1:0]  cfg_rail;
    logic [23:0] cfg_delay;
    logic [2:0]  ovr_val, good;
    logic [2:0]  rail_en, state;
    logic        done, fault;
    logic [1:0]  fault_rail;

    bsg_gateway_power_seq #(
        .num_rails_p(3), .delay_width_p(24), .default_delay_p(1000000),
        .good_timeout_p(4), .rail_id_width_p(2)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .cfg_v_i(cfg_v),
        .cfg_rail_i(cfg_rail), .cfg_delay_i(cfg_delay), .override_i(ovr),
        .override_val_i(ovr_val), .rail_good_i(good), .clear_fault_i(clr),
        .rail_en_o(rail_en), .done_o(done), .fault_o(fault),
        .fault_rail_o(fault_rail), .state_o(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      nm;
        int         c;
        logic [2:0] re;
        logic       d;
        logic       f;
        logic [1:0] fr;
        logic [2:0] st;
    } exp_t;

    exp_t       q[$];
    int         total = 0, bad = 0;
    logic [1:0] fr_now = 2'd0;

    task automatic ex(input string nm, input int c, input logic [2:0] re,
                      input logic d, input logic f, input logic [2:0] st);
        exp_t e;
        e.nm = nm; e.c = c; e.re = re; e.d = d; e.f = f; e.fr = fr_now; e.st = st;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.c != cyc ||
                {rail_en, done, fault, fault_rail, state} !== {e.re, e.d, e.f, e.fr, e.st}) begin
                bad++;
                $display("FAIL %s cyc=%0d(want %0d) got en=%b done=%b flt=%b fr=%0d st=%0d want en=%b done=%b flt=%b fr=%0d st=%0d",
                         e.nm, cyc, e.c, rail_en, done, fault, fault_rail, state,
                         e.re, e.d, e.f, e.fr, e.st);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] r, input logic [23:0] d);
        cfg_v = 1'b1; cfg_rail = r; cfg_delay = d;
        tick(1);
        cfg_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        en = 0; cfg_v = 0; cfg_rail = 0; cfg_delay = 0; ovr = 0; ovr_val = 0;
        good = 3'b111; clr = 0; rst_n = 0;
        tick(2);
        t = cyc;
        ex("reset", t, 3'b000, 0, 0, OFF);
        rst_n = 1;
        tick(1);

        // Nominal up with 5/7/0; a write during UP must not land.
        cfg(0, 5); cfg(1, 7); cfg(2, 0); cfg(3, 20);
        t = cyc; en = 1;
        ex("up_r0",     t+1,  3'b001, 0, 0, UP);
        ex("up_r1_pre", t+6,  3'b001, 0, 0, UP);
        ex("up_r1",     t+7,  3'b011, 0, 0, UP);
        ex("up_r2_pre", t+14, 3'b011, 0, 0, UP);
        ex("up_r2",     t+15, 3'b111, 0, 0, UP);
        ex("up_done",   t+16, 3'b111, 1, 0, ON);
        tick(3); cfg(2, 9);
        tick(12);

        // Override during ON, released with en still high.
        t = cyc; ovr = 1; ovr_val = 3'b101;
        ex("ovr_on",   t+1, 3'b101, 0, 0, OFF);
        ex("ovr_hold", t+3, 3'b101, 0, 0, OFF);
        ex("ovr_rel",  t+4, 3'b000, 0, 0, OFF);
        ex("ovr_resq", t+5, 3'b001, 0, 0, UP);
        tick(3); ovr = 0;
        tick(2); en = 0;
        ex("ovr_abort", t+6, 3'b000, 0, 0, DOWN);
        ex("ovr_off",   t+7, 3'b000, 0, 0, OFF);
        tick(2);

        // Power down from ON with 5/7/3; en re-raised mid DOWN.
        cfg(2, 3);
        t = cyc; en = 1;
        ex("pd_up_r1",  t+7,  3'b011, 0, 0, UP);
        ex("pd_up_pre", t+18, 3'b111, 0, 0, UP);
        ex("pd_on",     t+19, 3'b111, 1, 0, ON);
        tick(19);
        t = cyc; en = 0;
        ex("pd_r2",     t+1,  3'b011, 0, 0, DOWN);
        ex("pd_r1_pre", t+3,  3'b011, 0, 0, DOWN);
        ex("pd_r1",     t+4,  3'b001, 0, 0, DOWN);
        ex("pd_r0_pre", t+10, 3'b001, 0, 0, DOWN);
        ex("pd_r0",     t+11, 3'b000, 0, 0, DOWN);
        ex("pd_off",    t+12, 3'b000, 0, 0, OFF);
        ex("pd_reup",   t+13, 3'b001, 0, 0, UP);
        ex("pd_abort",  t+14, 3'b000, 0, 0, DOWN);
        ex("pd_off2",   t+15, 3'b000, 0, 0, OFF);
        tick(5); en = 1;
        tick(8); en = 0;
        tick(2);

        // Abort while rail1 settles.
        t = cyc; en = 1;
        ex("ab_r1",     t+7,  3'b011, 0, 0, UP);
        ex("ab_pre",    t+9,  3'b011, 0, 0, UP);
        ex("ab_r1off",  t+10, 3'b001, 0, 0, DOWN);
        ex("ab_r0_pre", t+16, 3'b001, 0, 0, DOWN);
        ex("ab_r0off",  t+17, 3'b000, 0, 0, DOWN);
        ex("ab_off",    t+18, 3'b000, 0, 0, OFF);
        tick(9); en = 0;
        tick(9);

        // Good drop in ON together with en=0: fault wins, lowest rail reported.
        t = cyc; en = 1;
        ex("onf_on", t+19, 3'b111, 1, 0, ON);
        tick(19);
        good = 3'b010; en = 0;
        ex("onf_fault", t+20, 3'b000, 0, 1, FLT);
        ex("onf_clear", t+21, 3'b000, 0, 0, OFF);
        tick(1); clr = 1;
        tick(1); clr = 0; good = 3'b111;

        // Good-window timeout on rail1.
        good = 3'b101;
        t = cyc; en = 1;
        ex("to_r1",  t+7,  3'b011, 0, 0, UP);
        ex("to_pre", t+18, 3'b011, 0, 0, UP);
        fr_now = 2'd1;
        ex("to_fault",    t+19, 3'b000, 0, 1, FLT);
        ex("to_hold_en1", t+21, 3'b000, 0, 1, FLT);
        ex("to_clear",    t+22, 3'b000, 0, 0, OFF);
        tick(19); clr = 1;
        tick(2); en = 0;
        tick(1); clr = 0; good = 3'b111;

        // Async reset mid-UP, then default delays keep rail1 off.
        t = cyc; en = 1;
        ex("rs_pre", t+7, 3'b011, 0, 0, UP);
        tick(8);
        rst_n = 0; en = 0; fr_now = 2'd0;
        ex("rs_async", t+8, 3'b000, 0, 0, OFF);
        tick(2);
        rst_n = 1; en = 1;
        ex("rs_up",    t+11, 3'b001, 0, 0, UP);
        ex("rs_dflt",  t+51, 3'b001, 0, 0, UP);
        ex("rs_abort", t+52, 3'b000, 0, 0, DOWN);
        ex("rs_off",   t+53, 3'b000, 0, 0, OFF);
        tick(41); en = 0;
        tick(3);

        if (q.size() != 0) begin
            $display("FAIL drain left=%0d want 0", q.size());
            bad += q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
